// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FSM state encoding,
// access size codes and the alignment rule used at request acceptance.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  // A dword access on a 32-bit datapath has no legal alignment, so it is
  // reported the same way as a misaligned address.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] addr_lo,
                                         input logic       dw64);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo[1:0];
      default: return !dw64 || (|addr_lo);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
// Ports:
//   lane      - byte lane of the access (low address bits)
//   size      - access size code
//   sign_ext  - sign-extend extracted load data when 1
//   wdata     - right-justified store data
//   rdata     - raw RAM read word
//   strobe    - per-lane write strobes for the access
//   wdata_sh  - store data moved to its lane position
//   rdata_ext - load data moved down to bit 0 and extended
module mau_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic [LB-1:0]         lane,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [NB-1:0]         strobe,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic [DATA_WIDTH-1:0] rdata_ext
);

  logic [NB-1:0]         base;
  logic [DATA_WIDTH-1:0] rdata_sh;
  logic                  sgn;
  int                    nbits;

  assign strobe   = base << lane;
  assign wdata_sh = wdata << {lane, 3'b000};
  assign rdata_sh = rdata >> {lane, 3'b000};

  always_comb begin
    base  = '1;
    nbits = DATA_WIDTH;
    sgn   = rdata_sh[DATA_WIDTH-1];
    case (size)
      SZ_BYTE: begin base = NB'(1);     nbits = 8;  sgn = rdata_sh[7];  end
      SZ_HALF: begin base = NB'(3);     nbits = 16; sgn = rdata_sh[15]; end
      SZ_WORD: begin base = NB'(4'hF);  nbits = 32; sgn = rdata_sh[31]; end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      rdata_ext[i] = (i < nbits) ? rdata_sh[i] : (sign_ext & sgn);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit for the MEM stage with a registered
// request/acknowledge RAM port.
// Ports:
//   clk, rst                  - clock, async active-high reset
//   req_*                     - request from EX/MEM, accepted on req_valid && req_ready
//   flush                     - squash current/incoming op
//   ram_*                     - RAM request (held until ram_ack), strobes, address, data
//   resp_*                    - one-cycle completion to WB with load data
//   exc_unaligned/exc_timeout - exception flags, valid with resp_valid
//   busy                      - stall to ID/EX while not idle
//
// state     | meaning
// ST_IDLE   | waiting for a request, req_ready high unless flushed
// ST_ACCESS | ram_en high, waiting for ram_ack or timeout
// ST_RESP   | one-cycle response to WB
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 15,
  localparam int NB = DATA_WIDTH / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_sign_ext,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_reg_addr,
  input  logic                  flush,
  output logic                  ram_en,
  output logic [NB-1:0]         ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic                  ram_ack,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [4:0]            resp_reg_addr,
  output logic                  resp_reg_write,
  output logic                  exc_unaligned,
  output logic                  exc_timeout,
  output logic                  busy
);

  mau_state_t            state, state_nx;
  logic [7:0]            wait_cnt;
  logic                  write_q, sign_q, flushed_q, exc_unal_q, exc_to_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [4:0]            reg_q;

  logic                  accept, misaligned, timed_out;
  logic [NB-1:0]         strobe;
  logic [DATA_WIDTH-1:0] wdata_sh, rdata_ext;

  assign accept     = req_valid && req_ready;
  assign misaligned = is_misaligned(req_size, req_addr[2:0], DATA_WIDTH == 64);
  assign timed_out  = (state == ST_ACCESS) && !ram_ack && (wait_cnt == 8'(MAX_WAIT - 1));

  mau_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
    .lane      (addr_q[LB-1:0]),
    .size      (size_q),
    .sign_ext  (sign_q),
    .wdata     (wdata_q),
    .rdata     (ram_read_data),
    .strobe    (strobe),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    ram_en     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        // Gated with rst so nothing is offered while reset is held.
        req_ready = !flush && !rst;
        if (accept) state_nx = misaligned ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_en = 1'b1;
        // A flushed op still runs to completion so a store commits, but
        // skips the response.
        if (ram_ack || timed_out) state_nx = (flushed_q || flush) ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        resp_valid = !flush;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= '0;
      write_q    <= 1'b0;
      sign_q     <= 1'b0;
      flushed_q  <= 1'b0;
      exc_unal_q <= 1'b0;
      exc_to_q   <= 1'b0;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      reg_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_cnt  <= '0;
          flushed_q <= 1'b0;
          if (accept) begin
            write_q    <= req_write;
            sign_q     <= req_sign_ext;
            size_q     <= req_size;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            reg_q      <= req_reg_addr;
            exc_unal_q <= misaligned;
            exc_to_q   <= 1'b0;
            rdata_q    <= '0;
          end
        end
        ST_ACCESS: begin
          if (flush) flushed_q <= 1'b1;
          exc_to_q <= timed_out;
          if (ram_ack) rdata_q <= write_q ? '0 : rdata_ext;
          else         wait_cnt <= wait_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign ram_write_en   = (ram_en && write_q) ? strobe : '0;
  assign ram_addr       = ram_en ? {addr_q[ADDR_WIDTH-1:LB], {LB{1'b0}}} : '0;
  assign ram_write_data = ram_en ? wdata_sh : '0;

  assign resp_data      = resp_valid ? rdata_q : '0;
  assign resp_reg_addr  = reg_q;
  assign exc_unaligned  = resp_valid && exc_unal_q;
  assign exc_timeout    = resp_valid && exc_to_q;
  assign resp_reg_write = resp_valid && !write_q && !exc_unal_q && !exc_to_q;

endmodule
